// File: rtl/serial_alu_pkg.sv
// Shared definitions for the bit-serial ALU controller.
// Holds the op codes driven to the 1-bit slice and the controller FSM state type.
package serial_alu_pkg;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_ADD  = 2'b10;
  localparam logic [1:0] OP_NOTA = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  // Only ADD propagates a carry through the slice chain.
  function automatic logic is_add(input logic [1:0] op);
    return op == OP_ADD;
  endfunction

endpackage

// File: rtl/serial_alu_ctrl.sv
// Bit-serial sequencer for one external 1-bit ALU slice (AND / OR / ADD / NOT A).
// Operand bits are presented LSB-first, the slice carry is looped back each
// cycle, and slice result bits are collected into a parallel word.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   start_i               request, sampled only in IDLE
//   op_i, a_i, b_i, cin_i operation and operands, latched with start_i
//   busy_o                high while bits are being processed
//   done_o                one-cycle pulse, result/flags valid
//   result_o              assembled result, held until the next accept
//   carry_out_o           carry out of MSB (ADD only)
//   overflow_o            signed overflow (ADD only)
//   slice_a_o, slice_b_o, slice_cin_o, slice_ctrl_o   drive to the slice
//   slice_s_i, slice_cout_i                           slice result / carry
module serial_alu_ctrl
  import serial_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_out_o,
  output logic             overflow_o,
  output logic             slice_a_o,
  output logic             slice_b_o,
  output logic             slice_cin_o,
  output logic [1:0]       slice_ctrl_o,
  input  logic             slice_s_i,
  input  logic             slice_cout_i
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] shift_a_q, shift_a_d;
  logic [WIDTH-1:0] shift_b_q, shift_b_d;
  logic             carry_q, carry_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_out_q, carry_out_d;
  logic             overflow_q, overflow_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      op_q        <= OP_AND;
      shift_a_q   <= '0;
      shift_b_q   <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      shift_a_q   <= shift_a_d;
      shift_b_q   <= shift_b_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    shift_a_d    = shift_a_q;
    shift_b_d    = shift_b_q;
    carry_d      = carry_q;
    cnt_d        = cnt_q;
    result_d     = result_q;
    carry_out_d  = carry_out_q;
    overflow_d   = overflow_q;
    slice_a_o    = 1'b0;
    slice_b_o    = 1'b0;
    slice_cin_o  = 1'b0;
    slice_ctrl_o = 2'b00;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d     = RUN;
          op_d        = op_i;
          shift_a_d   = a_i;
          shift_b_d   = b_i;
          carry_d     = is_add(op_i) & cin_i;
          cnt_d       = '0;
          result_d    = '0;
          carry_out_d = 1'b0;
          overflow_d  = 1'b0;
        end
      end
      RUN: begin
        slice_a_o    = shift_a_q[0];
        slice_b_o    = shift_b_q[0];
        slice_cin_o  = carry_q;
        slice_ctrl_o = op_q;
        // Result fills from the top so the first (LSB) bit lands at bit 0 after WIDTH shifts.
        result_d  = {slice_s_i, result_q[WIDTH-1:1]};
        shift_a_d = shift_a_q >> 1;
        shift_b_d = shift_b_q >> 1;
        carry_d   = is_add(op_q) & slice_cout_i;
        if (cnt_q == LastCnt) begin
          state_d     = DONE;
          carry_out_d = is_add(op_q) & slice_cout_i;
          // carry_q here is the carry into the MSB.
          overflow_d  = is_add(op_q) & (carry_q ^ slice_cout_i);
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy_o      = (state_q == RUN);
  assign done_o      = (state_q == DONE);
  assign result_o    = result_q;
  assign carry_out_o = carry_out_q;
  assign overflow_o  = overflow_q;

endmodule
